// File: rtl/am_pkg.sv
// Shared constants and types for the associative-memory search controller.
//   SEQ_CYCLE_COUNT : segments per hypervector (query_ctr is 4 bits, so <= 16)
//   DIMS_PER_CC     : bits per segment
//   NUM_CLASSES     : class hypervectors held in the AND array
//   SCORE_W / PC_W  : widths of a full overlap score / of one segment popcount
package am_pkg;

  localparam int SEQ_CYCLE_COUNT = 10;
  localparam int DIMS_PER_CC     = 100;
  localparam int NUM_CLASSES     = 26;

  localparam int SCORE_W = $clog2(SEQ_CYCLE_COUNT * DIMS_PER_CC + 1);
  localparam int PC_W    = $clog2(DIMS_PER_CC + 1);
  localparam int CLS_W   = $clog2(NUM_CLASSES);
  localparam int QC_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } am_state_e;

endpackage

// File: rtl/am_popcount.sv
// Combinational population count of one AND-array segment result.
//   bits_i  : W-bit vector to count
//   count_o : number of ones in bits_i
module am_popcount
  import am_pkg::*;
#(
  parameter int W = DIMS_PER_CC
) (
  input  logic [W-1:0]             bits_i,
  output logic [$clog2(W+1)-1:0]   count_o
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/am_search_ctrl.sv
// Sequences one associative-memory search over the time-multiplexed class-HV
// AND array: steps query_ctr over every segment, accumulates a per-class overlap
// score from the popcounted AND results, runs a one-class-per-cycle argmax and
// presents the winner on a valid/ready result port.
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a search (taken only when idle)
//   busy          : high whenever not idle
//   seg_valid/seg_ready, query_ctr, and_array_out : segment input port
//   res_valid/res_ready, res_class, res_score     : result output port
//   dbg_state_o   : current controller state
//
// Handshakes: a transfer happens on a cycle where valid and ready are both high.
// A producer holding valid keeps its data stable until that cycle; ready may be
// toggled freely and never depends combinationally on valid.
module am_search_ctrl
  import am_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   busy,
  input  logic                                   seg_valid,
  output logic                                   seg_ready,
  output logic [QC_W-1:0]                        query_ctr,
  input  logic [NUM_CLASSES-1:0][DIMS_PER_CC-1:0] and_array_out,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic [CLS_W-1:0]                       res_class,
  output logic [SCORE_W-1:0]                     res_score,
  output am_state_e                              dbg_state_o
);

  localparam logic [QC_W-1:0]  LAST_SEG = QC_W'(SEQ_CYCLE_COUNT - 1);
  localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASSES - 1);

  am_state_e           state_q, state_d;
  logic [QC_W-1:0]     qctr_q, qctr_d;
  logic [CLS_W-1:0]    k_q, k_d;
  logic [SCORE_W-1:0]  best_q, best_d;
  logic [CLS_W-1:0]    best_idx_q, best_idx_d;
  logic [SCORE_W-1:0]  acc_q [NUM_CLASSES];
  logic [SCORE_W-1:0]  acc_d [NUM_CLASSES];
  logic [PC_W-1:0]     pc    [NUM_CLASSES];

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_pc
    am_popcount #(.W(DIMS_PER_CC)) u_pc (
      .bits_i  (and_array_out[g]),
      .count_o (pc[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      qctr_q     <= '0;
      k_q        <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) acc_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      qctr_q     <= qctr_d;
      k_q        <= k_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      for (int i = 0; i < NUM_CLASSES; i++) acc_q[i] <= acc_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    qctr_d     = qctr_q;
    k_d        = k_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    for (int i = 0; i < NUM_CLASSES; i++) acc_d[i] = acc_q[i];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_CLASSES; i++) acc_d[i] = '0;
          qctr_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (seg_valid) begin
          for (int i = 0; i < NUM_CLASSES; i++) begin
            acc_d[i] = acc_q[i] + SCORE_W'(pc[i]);
          end
          if (qctr_q == LAST_SEG) begin
            qctr_d  = '0;
            k_d     = '0;
            state_d = ARGMAX;
          end else begin
            qctr_d = qctr_q + 1'b1;
          end
        end
      end
      ARGMAX: begin
        // Strict '>' keeps the earliest class on equal scores.
        if (k_q == '0 || acc_q[k_q] > best_q) begin
          best_d     = acc_q[k_q];
          best_idx_d = k_q;
        end
        if (k_q == LAST_CLS) begin
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        // start is not looked at here, so a simultaneous start is dropped.
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The argmax registers double as the result: they are frozen while in DONE.
  assign busy        = (state_q != IDLE);
  assign seg_ready   = (state_q == ACCUM);
  assign res_valid   = (state_q == DONE);
  assign query_ctr   = qctr_q;
  assign res_class   = best_idx_q;
  assign res_score   = best_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_am_search_ctrl.sv
module tb_am_search_ctrl;
  import am_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                    rst;
  logic                                    start;
  logic                                    busy;
  logic                                    seg_valid;
  logic                                    seg_ready;
  logic [QC_W-1:0]                         query_ctr;
  logic [NUM_CLASSES-1:0][DIMS_PER_CC-1:0] and_array_out;
  logic                                    res_valid;
  logic                                    res_ready;
  logic [CLS_W-1:0]                        res_class;
  logic [SCORE_W-1:0]                      res_score;
  am_state_e                               dbg_state;

  am_search_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .seg_valid     (seg_valid),
    .seg_ready     (seg_ready),
    .query_ctr     (query_ctr),
    .and_array_out (and_array_out),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_class     (res_class),
    .res_score     (res_score),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 collecting segments, 2 ranking, 3 result held.
  int m_phase = 0;
  int m_seg   = 0;
  int m_left  = 0;
  int m_sum [NUM_CLASSES];

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_seg   <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_phase <= 1;
             m_seg   <= 0;
             for (int c = 0; c < NUM_CLASSES; c++) m_sum[c] <= 0;
           end
        1: if (seg_valid) begin
             for (int c = 0; c < NUM_CLASSES; c++)
               m_sum[c] <= m_sum[c] + $countones(and_array_out[c]);
             if (m_seg == SEQ_CYCLE_COUNT - 1) begin
               m_phase <= 2;
               m_seg   <= 0;
               m_left  <= NUM_CLASSES;
             end else begin
               m_seg <= m_seg + 1;
             end
           end
        2: begin
             if (m_left == 1) m_phase <= 3;
             m_left <= m_left - 1;
           end
        default: if (res_ready) m_phase <= 0;
      endcase
    end
  end

  function automatic void model_best(output int ci, output int sc);
    sc = m_sum[0];
    ci = 0;
    for (int k = 1; k < NUM_CLASSES; k++) begin
      if (m_sum[k] > sc) begin
        sc = m_sum[k];
        ci = k;
      end
    end
  endfunction

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      int ec, es;
      chk("busy",      busy,      m_phase != 0);
      chk("seg_ready", seg_ready, m_phase == 1);
      chk("res_valid", res_valid, m_phase == 3);
      chk("state",     dbg_state, m_phase);
      chk("query_ctr", query_ctr, (m_phase == 1) ? m_seg : 0);
      if (m_phase == 3) begin
        model_best(ec, es);
        chk("res_class", res_class, ec);
        chk("res_score", res_score, es);
      end
    end
  end

  // ---------------- stimulus patterns ----------------
  logic [NUM_CLASSES-1:0][DIMS_PER_CC-1:0] pat [SEQ_CYCLE_COUNT];

  task automatic fill_counts(input int base, input int cls_a, input int n_a,
                             input int cls_b, input int n_b);
    for (int s = 0; s < SEQ_CYCLE_COUNT; s++)
      for (int c = 0; c < NUM_CLASSES; c++) begin
        int n;
        n = (c == cls_a) ? n_a : (c == cls_b) ? n_b : base;
        pat[s][c] = '0;
        for (int b = 0; b < n; b++) pat[s][c][b] = 1'b1;
      end
  endtask

  task automatic fill_random();
    int dens [NUM_CLASSES];
    for (int c = 0; c < NUM_CLASSES; c++) dens[c] = $urandom_range(0, 100);
    for (int s = 0; s < SEQ_CYCLE_COUNT; s++)
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int b = 0; b < DIMS_PER_CC; b++)
          pat[s][c][b] = ($urandom_range(0, 99) < dens[c]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_search();
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int stall_at, input int stall_len, input int abort_at);
    for (int s = 0; s < SEQ_CYCLE_COUNT; s++) begin
      and_array_out = pat[s];
      if (s == abort_at) begin
        rst       = 1'b1;
        seg_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",      busy,      0);
        chk("abort_query_ctr", query_ctr, 0);
        chk("abort_res_valid", res_valid, 0);
        and_array_out = '0;
        return;
      end
      if (s == stall_at) begin
        seg_valid = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          chk("stall_query_ctr", query_ctr, s);
        end
      end
      seg_valid = 1'b1;
      @(negedge clk);
    end
    seg_valid     = 1'b0;
    and_array_out = '0;
  endtask

  task automatic get_result(input int exp_lat, input bit check_lit,
                            input int exp_cls, input int exp_scr,
                            input int hold, input bit poke_start,
                            output int got_cls, output int got_scr);
    int n;
    n = 0;
    got_cls = -1;
    got_scr = -1;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      chk("res_timeout", 0, 1);
      return;
    end
    chk("latency", cyc - start_cyc, exp_lat);
    got_cls = int'(res_class);
    got_scr = int'(res_score);
    if (check_lit) begin
      chk("lit_class", got_cls, exp_cls);
      chk("lit_score", got_scr, exp_scr);
    end
    for (int h = 0; h < hold; h++) begin
      start = poke_start;
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_class", res_class, got_cls);
      chk("hold_score", res_score, got_scr);
    end
    // Accept the result; a start in the same cycle must be dropped.
    res_ready = 1'b1;
    start     = poke_start;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    chk("done_to_idle", busy, 0);
    chk("valid_drop",   res_valid, 0);
    @(negedge clk);
    chk("still_idle",   busy, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int c1, s1, c2, s2, sa, sl, hd;
    rst           = 1'b1;
    start         = 1'b0;
    seg_valid     = 1'b0;
    res_ready     = 1'b0;
    and_array_out = '0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset values.
    chk("rst_busy",      busy,      0);
    chk("rst_seg_ready", seg_ready, 0);
    chk("rst_query_ctr", query_ctr, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_class", res_class, 0);
    chk("rst_res_score", res_score, 0);

    // All-zero AND results.
    fill_counts(0, -1, 0, -1, 0);
    start_search();
    feed(-1, 0, -1);
    get_result(37, 1'b1, 0, 0, 2, 1'b0, c1, s1);

    // Class 7 all ones.
    fill_counts(0, 7, DIMS_PER_CC, -1, 0);
    start_search();
    feed(-1, 0, -1);
    get_result(37, 1'b1, 7, 1000, 0, 1'b0, c1, s1);

    // Tie between classes 3 and 12: lower index wins.
    fill_counts(5, 3, 40, 12, 40);
    start_search();
    feed(-1, 0, -1);
    get_result(37, 1'b1, 3, 400, 0, 1'b0, c1, s1);

    // Stall at segment 4 for 3 cycles: same answer, 3 cycles later.
    fill_random();
    start_search();
    feed(-1, 0, -1);
    get_result(37, 1'b0, 0, 0, 0, 1'b0, c1, s1);
    start_search();
    feed(4, 3, -1);
    get_result(40, 1'b0, 0, 0, 0, 1'b0, c2, s2);
    chk("stall_same_class", c2, c1);
    chk("stall_same_score", s2, s1);

    // Reset mid-search at segment 6, then a fresh search.
    fill_random();
    start_search();
    feed(-1, 0, 6);
    @(negedge clk);
    start_search();
    feed(-1, 0, -1);
    get_result(37, 1'b0, 0, 0, 0, 1'b0, c1, s1);

    // Result held 20 cycles with start poked throughout.
    fill_counts(0, 7, DIMS_PER_CC, -1, 0);
    start_search();
    feed(-1, 0, -1);
    get_result(37, 1'b1, 7, 1000, 20, 1'b1, c1, s1);

    // Randomised searches.
    for (int r = 0; r < 8; r++) begin
      fill_random();
      sa = $urandom_range(0, SEQ_CYCLE_COUNT - 1);
      sl = $urandom_range(0, 4);
      hd = $urandom_range(0, 5);
      start_search();
      feed(sa, sl, -1);
      get_result(37 + sl, 1'b0, 0, 0, hd, 1'($urandom_range(0, 1)), c1, s1);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
